// File: rtl/board_pkg.sv
// Board-wide constants and shared types for the push-button front end.
// Imported by the key conditioning logic and the board top level.
package board_pkg;

  localparam int unsigned SYS_CLK_HZ = 50_000_000;

  function automatic int unsigned ms_to_cycles(
    input int unsigned ms
  );
    return ms * (SYS_CLK_HZ / 1000);
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG
  } key_state_e;

endpackage

// File: rtl/key_debounce_if.sv
// Key pin in, clean level and press/release/long events out.
// master = the debouncer, slave = the consumer of the events.
interface key_debounce_if;

  logic key_in;
  logic key_level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic long_held;

  modport master (
    input  key_in,
    output key_level,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output long_held
  );

  modport slave (
    output key_in,
    input  key_level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse,
    input  long_held
  );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous board pins.
// RST_VAL lets each pin reset to its own idle level.
module sync_2ff #(
  parameter int          W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         sys_clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioner: sync, debounce, and press/release/long
// event generation for one key.
module key_debounce
  import board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic           sys_clk,
  input  logic           reset,
  key_debounce_if.master kif
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW = $clog2(LONG_CYCLES) + 1;

  localparam logic REL_LVL = (ACTIVE_LOW != 0);

  localparam logic [DW-1:0] DB_LAST =
    DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST =
    HW'(LONG_CYCLES - 1);

  logic          key_sync;
  logic          s;
  logic          diff;
  logic          accept;
  logic [DW-1:0] db_cnt;

  key_state_e    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d, hold_inc;
  logic          level_q, level_d;
  logic          held_q, held_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          long_q, long_d;

  sync_2ff #(
    .W       (1),
    .RST_VAL (REL_LVL)
  ) u_sync (
    .sys_clk (sys_clk),
    .reset   (reset),
    .d       (kif.key_in),
    .q       (key_sync)
  );

  // s is 1 while pressed, whatever the pin polarity
  assign s      = key_sync ^ REL_LVL;
  assign diff   = (s != level_q);
  assign accept = diff && (db_cnt == DB_LAST);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      db_cnt <= '0;
    end else if (!diff || accept) begin
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DW'(1);
    end
  end

  assign hold_inc = (&hold_q) ? hold_q
                              : hold_q + HW'(1);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      level_q <= 1'b0;
      held_q  <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      level_q <= level_d;
      held_q  <= held_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    level_d = level_q;
    held_d  = held_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = PRESSED;
          press_d = 1'b1;
          level_d = 1'b1;
          hold_d  = '0;
        end
      end
      PRESSED: begin
        hold_d = hold_inc;
        // release beats a long threshold on the same edge
        if (accept) begin
          state_d = IDLE;
          rel_d   = 1'b1;
          level_d = 1'b0;
        end else if (hold_inc == LONG_LAST) begin
          state_d = LONG;
          long_d  = 1'b1;
          held_d  = 1'b1;
        end
      end
      LONG: begin
        if (accept) begin
          state_d = IDLE;
          rel_d   = 1'b1;
          level_d = 1'b0;
          held_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        level_d = 1'b0;
        held_d  = 1'b0;
      end
    endcase
  end

  assign kif.key_level     = level_q;
  assign kif.press_pulse   = press_q;
  assign kif.release_pulse = rel_q;
  assign kif.long_pulse    = long_q;
  assign kif.long_held     = held_q;

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Upstream conditioning stage for the board push-buttons (SW2/SW3): synchronises the raw pin, filters bounce, and emits a clean level plus single-cycle press, release and long-press events.
- Output feeds the LED blink/toggle logic and reset-request logic in the board top level, replacing direct use of raw key pins.
- One instance per key.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable sampled cycles required to accept a new level (20 ms at 50 MHz); must be >= 2.
- LONG_CYCLES, 50000000, cycles the key must stay accepted-pressed (counted from the press event) before long_pulse fires (1 s at 50 MHz); must be > DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.

Ports:
- sys_clk  input  1  system clock, 50 MHz
- reset  input  1  synchronous, active-high reset
- key_in  input  1  raw asynchronous key pin
- key_level  output  1  debounced state, 1 = pressed
- press_pulse  output  1  one-cycle strobe when a press is accepted
- release_pulse  output  1  one-cycle strobe when a release is accepted
- long_pulse  output  1  one-cycle strobe when a held press reaches LONG_CYCLES
- long_held  output  1  high from long_pulse until release is accepted

Behaviour:
- Reset (synchronous, sampled on sys_clk rising edge):
  - All outputs 0.
  - Synchroniser flops load the released level.
  - Debounce and hold counters cleared; FSM to IDLE.
  - Reset asserted mid-press drops key_level and long_held on the next edge with no release_pulse.
- Input path:
  - 2-flop synchroniser.
  - Polarity normalised to pressed = 1 after the synchroniser.
  - Call the result s.
- Debounce counter:
  - Width = clog2(DEBOUNCE_CYCLES) + 1.
  - Clears whenever s equals key_level; increments while s differs.
  - On reaching DEBOUNCE_CYCLES - 1 with s still differing, the new level is accepted on that edge.
  - Any glitch back to the accepted level before acceptance clears the counter; no event is produced.
- Latency: raw pin edge to key_level / press_pulse / release_pulse = 2 + DEBOUNCE_CYCLES cycles.
- FSM states:
  - IDLE: key_level = 0. Acceptance of a press goes to PRESSED; press_pulse = 1 and key_level -> 1 on the same edge; hold counter cleared.
  - PRESSED: hold counter increments each cycle, saturating.
    - Hold counter reaching LONG_CYCLES - 1 goes to LONG; long_pulse = 1 and long_held -> 1 on that edge.
    - Acceptance of a release goes to IDLE; release_pulse = 1 and key_level -> 0.
  - LONG: hold counter frozen. Acceptance of a release goes to IDLE; release_pulse = 1, key_level -> 0, long_held -> 0 on the same edge.
- Simultaneous events: if release acceptance and the long threshold fall on the same edge, release wins. release_pulse fires, long_pulse does not, and the FSM goes to IDLE.
- Exclusivity: at most one of press_pulse / release_pulse / long_pulse is high in any cycle. Each pulse is exactly one cycle wide.
- Hold counter:
  - Width = clog2(LONG_CYCLES) + 1.
  - Never wraps; held at its value in LONG.
- No repeat: a single continuous hold yields exactly one long_pulse.

Decomposition:
- Shared package board_pkg:
  - SYS_CLK_HZ = 50000000.
  - ms_to_cycles constant function.
  - Key state enum {IDLE, PRESSED, LONG}.
- One sub-module: sync_2ff, a generic 2-flop synchroniser with a reset-value parameter. It is reused by other pin inputs in the top level.
- The debounce counter and FSM stay in key_debounce.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1.
1. Reset release with key_in held 1 for 50 cycles -> all outputs stay 0; no pulses.
2. key_in 1->0 held 30 cycles, then 0->1 -> press_pulse exactly 6 cycles after the falling edge; key_level=1. long_pulse 19 cycles after press_pulse; long_held=1. release_pulse 6 cycles after the rising edge; key_level=0 and long_held=0 on the same edge.
3. Bounce: key_in toggles 1,0,1,0,1,0 at 2-cycle intervals, then holds 0 -> exactly one press_pulse, 6 cycles after the final falling edge; no other pulses.
4. Short press: key_in low for 10 cycles -> one press_pulse, one release_pulse, zero long_pulse; key_level high for exactly 10 cycles.
5. Release coincident with long threshold: time the accepted release to land on hold count 19 -> release_pulse=1, long_pulse never asserted, FSM back to IDLE.
6. Reset pulse while in LONG -> next edge key_level=0, long_held=0, no release_pulse. With key_in still 0 after reset, a fresh press_pulse follows 6 cycles later.
